// File: rtl/cpc_ram_bank_ctrl.sv
// CPC expansion RAM banking controller.
// Snoops Gate Array RAM-configuration writes, decodes the CPU memory
// windows that map to expansion SRAM, and sequences the SRAM strobes.
module cpc_ram_bank_ctrl #(
  parameter int WE_DELAY  = 1,
  parameter int BANK_BITS = 3
) (
  input  logic                 CLK,
  input  logic                 RESET_B,
  input  logic                 A15,
  input  logic                 A14,
  input  logic [7:0]           D,
  input  logic                 MREQ_B,
  input  logic                 IOREQ_B,
  input  logic                 RD_B,
  input  logic                 WR_B,
  input  logic                 M1_B,
  input  logic                 RFSH_B,
  input  logic                 RAMRD_B,
  output logic [BANK_BITS+1:0] HIADR,
  output logic                 RAMCS_B,
  output logic                 RAMOE_B,
  output logic                 RAMWE_B,
  output logic                 RAMDIS
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    WR_WAIT  = 3'd2,
    WR_PULSE = 3'd3,
    DONE     = 3'd4
  } state_t;

  // Write-settle counter preload; WE_DELAY=0 bypasses WR_WAIT entirely.
  localparam int WCNT_INIT = (WE_DELAY > 0) ? (WE_DELAY - 1) : 0;

  logic [BANK_BITS-1:0] r_cfg_bank;
  logic [2:0]           r_cfg_mode;
  logic                 r_io_armed;
  state_t               r_state;
  logic [1:0]           r_wcnt;
  logic [BANK_BITS+1:0] r_hiadr;
  logic                 r_cs_b;
  logic                 r_oe_b;
  logic                 r_we_b;

  logic [1:0] w_win;
  logic       w_hit;
  logic [1:0] w_page;
  logic       w_mem_cyc;
  logic       w_rd_hit;
  logic       w_wr_hit;
  logic       w_cfg_wr;

  assign w_win     = {A15, A14};
  assign w_mem_cyc = w_hit & ~MREQ_B & RFSH_B;
  assign w_rd_hit  = w_mem_cyc & ~RD_B & ~RAMRD_B;
  assign w_wr_hit  = w_mem_cyc & ~WR_B;
  // MREQ_B=1 is part of the qualifier, so a memory cycle always beats a config write.
  assign w_cfg_wr  = ~IOREQ_B & ~WR_B & M1_B & MREQ_B & ~A15 & (D[7:6] == 2'b11) & r_io_armed;

  assign RAMDIS  = w_mem_cyc & (~RAMRD_B | ~WR_B);
  assign HIADR   = r_hiadr;
  assign RAMCS_B = r_cs_b;
  assign RAMOE_B = r_oe_b;
  assign RAMWE_B = r_we_b;

  // Map the 16K CPU window onto an expansion page for the current mode.
  always_comb begin
    w_hit  = 1'b0;
    w_page = 2'd0;
    case (r_cfg_mode)
      3'd1, 3'd3: begin
        if (w_win == 2'd3) begin
          w_hit  = 1'b1;
          w_page = 2'd3;
        end
      end
      3'd2: begin
        w_hit  = 1'b1;
        w_page = w_win;
      end
      3'd4, 3'd5, 3'd6, 3'd7: begin
        if (w_win == 2'd1) begin
          w_hit  = 1'b1;
          w_page = r_cfg_mode[1:0];
        end
      end
      default: begin
        w_hit  = 1'b0;
        w_page = 2'd0;
      end
    endcase
  end

  // Capture bank/mode once per I/O cycle; re-arm whenever IOREQ_B is high.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      r_cfg_bank <= '0;
      r_cfg_mode <= 3'd0;
      r_io_armed <= 1'b1;
    end else if (IOREQ_B) begin
      r_io_armed <= 1'b1;
    end else if (w_cfg_wr) begin
      r_cfg_bank <= BANK_BITS'(D[5:3]);
      r_cfg_mode <= D[2:0];
      r_io_armed <= 1'b0;
    end
  end

  // SRAM access sequencer with registered strobes and page address.
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      r_state <= IDLE;
      r_wcnt  <= 2'd0;
      r_hiadr <= '0;
      r_cs_b  <= 1'b1;
      r_oe_b  <= 1'b1;
      r_we_b  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_rd_hit) begin
            r_state <= READ;
            r_hiadr <= {r_cfg_bank, w_page};
            r_cs_b  <= 1'b0;
            r_oe_b  <= 1'b0;
          end else if (w_wr_hit) begin
            r_hiadr <= {r_cfg_bank, w_page};
            r_cs_b  <= 1'b0;
            r_wcnt  <= 2'(WCNT_INIT);
            if (WE_DELAY == 0) begin
              r_state <= WR_PULSE;
              r_we_b  <= 1'b0;
            end else begin
              r_state <= WR_WAIT;
            end
          end
        end
        READ: begin
          if (MREQ_B) begin
            r_state <= IDLE;
            r_oe_b  <= 1'b1;
            r_cs_b  <= 1'b1;
          end
        end
        WR_WAIT: begin
          if (MREQ_B) begin
            r_state <= IDLE;
            r_cs_b  <= 1'b1;
          end else if (r_wcnt == 2'd0) begin
            r_state <= WR_PULSE;
            r_we_b  <= 1'b0;
          end else begin
            r_wcnt <= r_wcnt - 2'd1;
          end
        end
        WR_PULSE: begin
          if (WR_B || MREQ_B) begin
            r_state <= DONE;
            r_we_b  <= 1'b1;
          end
        end
        DONE: begin
          if (MREQ_B) begin
            r_state <= IDLE;
            r_cs_b  <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_cs_b  <= 1'b1;
          r_oe_b  <= 1'b1;
          r_we_b  <= 1'b1;
        end
      endcase
    end
  end

endmodule
